// File: rtl/RegisterAndDescriptorDefines.sv
// RegisterAndDescriptorDefines: opcodes, header layout, FSM encoding and beat-count helper
package RegisterAndDescriptorDefines;
  localparam int LEN_W = 20;
  typedef enum logic [3:0] {OP_NOP = 4'd0, OP_STREAM = 4'd1, OP_FRAMEBUFFER = 4'd2} opcode_t;
  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    HEADER    = 3'd1,
    STREAM    = 3'd2,
    DRAIN     = 3'd3,
    FB_WAIT   = 3'd4
  } state_t;
  typedef struct packed {
    logic [3:0] op;
    logic [3:0] ch;
    logic [3:0] user;
    logic [LEN_W-1:0] len;
  } header_t;
  function automatic logic [LEN_W-1:0] beat_count(input logic [LEN_W-1:0] len, input int shift);
    logic [LEN_W:0] s;
    s = {1'b0, len} + (((LEN_W+1)'(1) << shift) - (LEN_W+1)'(1));
    return LEN_W'(s >> shift);
  endfunction
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: output register plus one-entry skid; s_ready is a pure register decode
module axis_skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             aclk,
  input  logic             resetn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  assign s_ready = !skid_valid;
  always_ff @(posedge aclk or negedge resetn)
    if (!resetn) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!skid_valid) begin
      if (!m_valid || m_ready) begin
        m_valid <= s_valid;
        m_data  <= s_data;
      end else if (s_valid) begin
        skid_valid <= 1'b1;
        skid_data  <= s_data;
      end
    end else if (m_ready) begin
      m_data     <= skid_data;
      skid_valid <= 1'b0;
    end
endmodule

// File: rtl/cmd_stream_router.sv
// cmd_stream_router: parses command headers and routes counted payload beats to one channel,
// drains unknown channels, and hands framebuffer commands to the fb interface.
module cmd_stream_router
  import RegisterAndDescriptorDefines::*;
#(
  parameter int CMD_STREAM_WIDTH = 32,
  parameter int NUM_CHANNELS     = 5,
  parameter int RENDER_CHANNEL   = 1
) (
  input  logic                        aclk,
  input  logic                        resetn,
  input  logic                        s_cmd_axis_tvalid,
  output logic                        s_cmd_axis_tready,
  input  logic                        s_cmd_axis_tlast,
  input  logic [CMD_STREAM_WIDTH-1:0] s_cmd_axis_tdata,
  output logic [CMD_STREAM_WIDTH-1:0] m_cmd_axis_tdata,
  output logic [3:0]                  m_cmd_axis_tuser,
  output logic                        m_cmd_axis_tlast,
  output logic [NUM_CHANNELS-1:0]     m_cmd_axis_tvalid,
  input  logic [NUM_CHANNELS-1:0]     m_cmd_axis_tready,
  input  logic                        rasterizerRunning,
  input  logic                        pixelInPipeline,
  output logic                        startRendering,
  output logic                        fbApply,
  output logic [3:0]                  fbCmd,
  input  logic                        fbApplied,
  output logic                        errUnknownChannel,
  output logic [2:0]                  dbgState
);
  localparam int SHIFT = $clog2(CMD_STREAM_WIDTH / 8);
  localparam logic [4:0] NUM_CH = 5'(NUM_CHANNELS);
  localparam logic [3:0] RENDER = 4'(RENDER_CHANNEL);
  state_t state, state_n;
  header_t hdr;
  logic [LEN_W-1:0] cnt, hdr_beats;
  logic [3:0] ch;
  logic [NUM_CHANNELS-1:0] sel;
  logic bad_ch, sk_in_valid, sk_in_ready, sk_valid, out_ready, last_out, fire, unused_tlast;
  logic [CMD_STREAM_WIDTH:0] sk_out;
  assign unused_tlast = s_cmd_axis_tlast;
  assign hdr = header_t'(s_cmd_axis_tdata[31:0]);
  assign hdr_beats = beat_count(hdr.len, SHIFT);
  assign bad_ch = {1'b0, hdr.ch} >= NUM_CH;
  assign sel = NUM_CHANNELS'(1) << ch;
  assign out_ready = |(m_cmd_axis_tready & sel);
  assign last_out = sk_valid && m_cmd_axis_tlast && out_ready;
  // Payload intake stops once the counted beats are in, so the next header is never swallowed.
  assign sk_in_valid = state == STREAM && cnt != '0 && s_cmd_axis_tvalid;
  assign s_cmd_axis_tready = state == HEADER || state == DRAIN || (state == STREAM && cnt != '0 && sk_in_ready);
  assign fire = s_cmd_axis_tvalid && s_cmd_axis_tready;
  assign {m_cmd_axis_tlast, m_cmd_axis_tdata} = sk_out;
  assign m_cmd_axis_tvalid = sk_valid ? sel : '0;
  assign dbgState = state;
  axis_skid_buffer #(.WIDTH(CMD_STREAM_WIDTH + 1)) u_skid (
    .aclk    (aclk),
    .resetn  (resetn),
    .s_valid (sk_in_valid),
    .s_ready (sk_in_ready),
    .s_data  ({cnt == LEN_W'(1), s_cmd_axis_tdata}),
    .m_valid (sk_valid),
    .m_ready (out_ready),
    .m_data  (sk_out)
  );
  always_comb begin
    state_n = state;
    unique case (state)
      WAIT_IDLE: state_n = (!rasterizerRunning && !pixelInPipeline && fbApplied && !fbApply && !startRendering) ? HEADER : WAIT_IDLE;
      HEADER: if (s_cmd_axis_tvalid)
        state_n = hdr.op == OP_STREAM ? (hdr_beats == '0 ? WAIT_IDLE : bad_ch ? DRAIN : STREAM)
                : hdr.op == OP_FRAMEBUFFER ? FB_WAIT : WAIT_IDLE;
      STREAM:  state_n = last_out ? WAIT_IDLE : STREAM;
      DRAIN:   state_n = (s_cmd_axis_tvalid && cnt == LEN_W'(1)) ? WAIT_IDLE : DRAIN;
      FB_WAIT: state_n = fbApplied ? FB_WAIT : WAIT_IDLE;
      default: state_n = WAIT_IDLE;
    endcase
  end
  always_ff @(posedge aclk or negedge resetn)
    if (!resetn) begin
      state             <= WAIT_IDLE;
      cnt               <= '0;
      ch                <= '0;
      m_cmd_axis_tuser  <= '0;
      startRendering    <= 1'b0;
      fbApply           <= 1'b0;
      fbCmd             <= '0;
      errUnknownChannel <= 1'b0;
    end else begin
      state <= state_n;
      if (state == HEADER && s_cmd_axis_tvalid) begin
        cnt              <= hdr_beats;
        ch               <= hdr.ch;
        m_cmd_axis_tuser <= hdr.user;
      end else if (fire) cnt <= cnt - LEN_W'(1);
      if (state == HEADER && state_n == DRAIN) errUnknownChannel <= 1'b1;
      if (state == HEADER && state_n == FB_WAIT) begin
        fbApply <= 1'b1;
        fbCmd   <= hdr.len[3:0];
      end else if (state == FB_WAIT && !fbApplied) fbApply <= 1'b0;
      startRendering <= (state == STREAM && last_out && ch == RENDER) || (startRendering && !rasterizerRunning);
    end
endmodule

// File: tb/tb_cmd_stream_router.sv
// tb_cmd_stream_router: directed checks on a 32-bit and a 64-bit router instance
module tb_cmd_stream_router;
  logic aclk = 0, resetn = 1;
  always #5 aclk = ~aclk;
  logic vA, vB, trA, trB, mlA, mlB, tog, phase = 0;
  logic [31:0] dA, mdA;
  logic [63:0] dB, mdB;
  logic [3:0] muA, muB, fcA, fcB;
  logic [4:0] mvA, mvB, mrA, mrB, rdyA, rdyB;
  logic rr, pip, fba, srA, srB, fbA, fbB, errA, errB;
  logic [2:0] stA, stB;
  int errors = 0, checks = 0, cyc = 0;
  assign mrA = tog ? {5{phase}} : rdyA;
  assign mrB = rdyB;
  always @(posedge aclk) begin
    phase <= ~phase;
    cyc   <= cyc + 1;
  end
  cmd_stream_router u_dut (
    .aclk(aclk), .resetn(resetn),
    .s_cmd_axis_tvalid(vA), .s_cmd_axis_tready(trA), .s_cmd_axis_tlast(1'b0), .s_cmd_axis_tdata(dA),
    .m_cmd_axis_tdata(mdA), .m_cmd_axis_tuser(muA), .m_cmd_axis_tlast(mlA),
    .m_cmd_axis_tvalid(mvA), .m_cmd_axis_tready(mrA),
    .rasterizerRunning(rr), .pixelInPipeline(pip), .startRendering(srA),
    .fbApply(fbA), .fbCmd(fcA), .fbApplied(fba), .errUnknownChannel(errA), .dbgState(stA)
  );
  cmd_stream_router #(.CMD_STREAM_WIDTH(64)) u_dut64 (
    .aclk(aclk), .resetn(resetn),
    .s_cmd_axis_tvalid(vB), .s_cmd_axis_tready(trB), .s_cmd_axis_tlast(1'b0), .s_cmd_axis_tdata(dB),
    .m_cmd_axis_tdata(mdB), .m_cmd_axis_tuser(muB), .m_cmd_axis_tlast(mlB),
    .m_cmd_axis_tvalid(mvB), .m_cmd_axis_tready(mrB),
    .rasterizerRunning(rr), .pixelInPipeline(pip), .startRendering(srB),
    .fbApply(fbB), .fbCmd(fcB), .fbApplied(fba), .errUnknownChannel(errB), .dbgState(stB)
  );
  typedef struct {
    logic [4:0]  v;
    logic        last;
    logic [3:0]  user;
    logic [63:0] data;
    int          cyc;
  } beat_t;
  beat_t qa[$], qb[$];
  always @(negedge aclk) begin
    if (|(mvA & mrA)) qa.push_back('{mvA, mlA, muA, {32'h0, mdA}, cyc});
    if (|(mvB & mrB)) qb.push_back('{mvB, mlB, muB, mdB, cyc});
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask
  task automatic send(input bit b, input logic [63:0] d);
    int n = 0;
    if (b) begin vB = 1; dB = d; end else begin vA = 1; dA = d[31:0]; end
    do begin
      @(negedge aclk);
      n++;
    end while (!(b ? trB : trA) && n < 100);
    chk("send_accept", 64'(n < 100), 1);
    @(posedge aclk);
    #1;
    vA = 0;
    vB = 0;
  endtask
  task automatic wait_st(input bit b, input logic [2:0] st, input string tag);
    int n = 0;
    while ((b ? stB : stA) != st && n < 200) begin
      tick();
      n++;
    end
    chk(tag, b ? stB : stA, st);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vA = 0; vB = 0; dA = 0; dB = 0; rdyA = '1; rdyB = '1; tog = 0; rr = 0; pip = 0; fba = 1;
    #1 resetn = 0;
    #1;
    chk("rst_tready", trA, 0);
    chk("rst_tvalid", mvA, 0);
    chk("rst_tlast", mlA, 0);
    chk("rst_start", srA, 0);
    chk("rst_fbapply", fbA, 0);
    chk("rst_fbcmd", fcA, 0);
    chk("rst_err", errA, 0);
    chk("rst_state", stA, 0);
    tick(3);
    resetn = 1;
    tick(2);
    chk("idle_to_header", stA, 1);
    chk("header_tready", trA, 1);
    // ch2 len16 on 32-bit: 4 back-to-back beats
    send(0, 64'h1220_0010);
    for (int i = 0; i < 4; i++) send(0, 64'hA000_0000 + 64'(i));
    wait_st(0, 1, "s1_done");
    chk("s1_count", 64'(qa.size()), 4);
    for (int i = 0; i < qa.size(); i++) begin
      chk("s1_data", qa[i].data, 64'hA000_0000 + 64'(i));
      chk("s1_valid", qa[i].v, 5'b00100);
      chk("s1_last", qa[i].last, i == 3);
      chk("s1_user", qa[i].user, 2);
      chk("s1_consec", 64'(qa[i].cyc), 64'(qa[0].cyc + i));
    end
    chk("s1_no_start", srA, 0);
    // ch1 len20 on 64-bit: 3 beats, render start
    wait_st(1, 1, "b_header");
    send(1, 64'h0000_0000_1130_0014);
    for (int i = 0; i < 3; i++) send(1, 64'h1111_2222_0000_0000 + 64'(i));
    wait_st(1, 0, "b_done");
    chk("b_count", 64'(qb.size()), 3);
    for (int i = 0; i < qb.size(); i++) begin
      chk("b_data", qb[i].data, 64'h1111_2222_0000_0000 + 64'(i));
      chk("b_valid", qb[i].v, 5'b00010);
      chk("b_last", qb[i].last, i == 2);
    end
    chk("b_start_set", srB, 1);
    tick(3);
    chk("b_start_held", srB, 1);
    chk("b_blocked", stB, 0);
    rr = 1;
    tick();
    rr = 0;
    chk("b_start_clear", srB, 0);
    tick(2);
    chk("b_resume", stB, 1);
    // ch0 len32 with downstream ready toggling
    qa.delete();
    tog = 1;
    send(0, 64'h1000_0020);
    for (int i = 0; i < 8; i++) send(0, 64'hC0DE_0000 + 64'(i));
    wait_st(0, 1, "tog_done");
    tog = 0;
    chk("tog_count", 64'(qa.size()), 8);
    for (int i = 0; i < qa.size(); i++) begin
      chk("tog_data", qa[i].data, 64'hC0DE_0000 + 64'(i));
      chk("tog_valid", qa[i].v, 5'b00001);
      chk("tog_last", qa[i].last, i == 7);
    end
    // unknown channel 7 is drained
    qa.delete();
    send(0, 64'h1700_0008);
    chk("drain_state", stA, 3);
    chk("drain_err", errA, 1);
    send(0, 64'hDEAD_0000);
    send(0, 64'hDEAD_0001);
    wait_st(0, 1, "drain_done");
    chk("drain_no_out", 64'(qa.size()), 0);
    send(0, 64'h1340_0004);
    send(0, 64'hBEEF_0001);
    wait_st(0, 1, "after_drain_done");
    chk("after_drain_count", 64'(qa.size()), 1);
    if (qa.size() > 0) begin
      chk("after_drain_data", qa[0].data, 64'hBEEF_0001);
      chk("after_drain_valid", qa[0].v, 5'b01000);
      chk("after_drain_last", qa[0].last, 1);
      chk("after_drain_user", qa[0].user, 4);
    end
    // zero length, then ceil rounding on the highest channel
    qa.delete();
    send(0, 64'h1200_0000);
    chk("len0_idle", stA, 0);
    wait_st(0, 1, "len0_back");
    chk("len0_no_out", 64'(qa.size()), 0);
    send(0, 64'h1450_0005);
    send(0, 64'h5500_0000);
    send(0, 64'h5500_0001);
    wait_st(0, 1, "len5_done");
    chk("len5_count", 64'(qa.size()), 2);
    for (int i = 0; i < qa.size(); i++) begin
      chk("len5_valid", qa[i].v, 5'b10000);
      chk("len5_last", qa[i].last, i == 1);
    end
    // framebuffer command handshake
    send(0, 64'h2000_000F);
    chk("fb_apply", fbA, 1);
    chk("fb_cmd", fcA, 4'hF);
    chk("fb_state", stA, 4);
    tick();
    chk("fb_apply_hold", fbA, 1);
    fba = 0;
    tick();
    chk("fb_apply_clear", fbA, 0);
    chk("fb_idle", stA, 0);
    tick(2);
    chk("fb_no_header", trA, 0);
    fba = 1;
    tick();
    chk("fb_header_again", stA, 1);
    chk("fb_tready_again", trA, 1);
    fba = 0;
    send(0, 64'h2000_0005);
    chk("fb0_apply", fbA, 1);
    chk("fb0_cmd", fcA, 4'h5);
    tick();
    chk("fb0_apply_clear", fbA, 0);
    fba = 1;
    wait_st(0, 1, "fb0_back");
    // reset in the middle of a stream
    chk("err_sticky", errA, 1);
    qa.delete();
    rdyA = '0;
    send(0, 64'h1300_0010);
    send(0, 64'h7700_0000);
    send(0, 64'h7700_0001);
    chk("mid_valid", mvA, 5'b01000);
    #2 resetn = 0;
    #1;
    chk("mid_rst_valid", mvA, 0);
    chk("mid_rst_tready", trA, 0);
    chk("mid_rst_tlast", mlA, 0);
    chk("mid_rst_state", stA, 0);
    chk("mid_rst_err", errA, 0);
    chk("mid_rst_fbcmd", fcA, 0);
    tick();
    resetn = 1;
    rdyA = '1;
    wait_st(0, 1, "post_rst_header");
    send(0, 64'h1060_0004);
    send(0, 64'h1234_5678);
    wait_st(0, 1, "post_rst_done");
    chk("post_rst_count", 64'(qa.size()), 1);
    if (qa.size() > 0) begin
      chk("post_rst_data", qa[0].data, 64'h1234_5678);
      chk("post_rst_valid", qa[0].v, 5'b00001);
      chk("post_rst_last", qa[0].last, 1);
      chk("post_rst_user", qa[0].user, 6);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cmd_stream_router.md
CMD_STREAM_ROUTER -- requirements
Module: cmd_stream_router

Interface
REQ-001 Parameter CMD_STREAM_WIDTH, default 32, command/payload data width in bits; legal values 32, 64, 128.
REQ-002 Parameter NUM_CHANNELS, default 5, number of downstream payload channels; legal range 1..8.
REQ-003 Parameter RENDER_CHANNEL, default 1, channel whose completed stream raises startRendering.
REQ-004 aclk  in  1  single clock; all logic on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 s_cmd_axis_tvalid/tready/tlast/tdata  in/out/in/in  1/1/1/CMD_STREAM_WIDTH  AXIS command input.
REQ-007 m_cmd_axis_tdata  out  CMD_STREAM_WIDTH  shared payload data to all channels.
REQ-008 m_cmd_axis_tuser  out  4  tuser field from the stream header.
REQ-009 m_cmd_axis_tlast  out  1  last payload beat of the stream.
REQ-010 m_cmd_axis_tvalid  out  NUM_CHANNELS  one-hot per-channel valid.
REQ-011 m_cmd_axis_tready  in  NUM_CHANNELS  per-channel ready.
REQ-012 rasterizerRunning, pixelInPipeline  in  1 each  pipeline busy indicators.
REQ-013 startRendering  out  1  render start request.
REQ-014 fbApply  out  1  framebuffer command request; fbCmd  out  4  {memset, commit, depthSel, colorSel}; fbApplied  in  1  framebuffer idle/done.
REQ-015 errUnknownChannel  out  1  sticky error flag; dbgState  out  3  current state.

Function
REQ-016 Header word is the low 32 bits of a beat: [31:28] opcode (0 NOP, 1 STREAM, 2 FRAMEBUFFER, others treated as NOP), [27:24] channel, [23:20] tuser, [19:0] payload length in bytes.
REQ-017 States SHALL be WAIT_IDLE, HEADER, STREAM, DRAIN, FB_WAIT.
REQ-018 WAIT_IDLE -> HEADER when !rasterizerRunning, !pixelInPipeline, fbApplied, !fbApply and !startRendering; s_cmd_axis_tready is 0 in WAIT_IDLE.
REQ-019 HEADER: tready=1; a header is consumed on tvalid&tready.
REQ-020 Beat count is ceil(length / (CMD_STREAM_WIDTH/8)), held in a 20-bit counter.
REQ-021 STREAM with count 0 -> WAIT_IDLE; channel >= NUM_CHANNELS -> DRAIN and errUnknownChannel set; otherwise -> STREAM; NOP -> WAIT_IDLE.
REQ-022 STREAM: output stage plus 1-entry skid buffer; sustained 1 beat/cycle when the selected channel ready is held high; s_cmd_axis_tready is registered and deasserts only when the skid buffer is occupied.
REQ-023 Only bit [channel] of m_cmd_axis_tvalid may be 1; data/tuser/tlast are stable while valid and not ready.
REQ-024 m_cmd_axis_tlast=1 on the beat where the counter reaches 1; the input tlast is ignored for framing.
REQ-025 After the last beat is accepted downstream: if channel==RENDER_CHANNEL, startRendering=1; -> WAIT_IDLE.
REQ-026 startRendering stays 1 until rasterizerRunning is seen high, then clears.
REQ-027 DRAIN: tready=1 and beats are discarded; no output valid; -> WAIT_IDLE after the counted beat.
REQ-028 FRAMEBUFFER: latch fbCmd=header[3:0], fbApply=1, -> FB_WAIT; fbApply clears on the first cycle fbApplied=0; then -> WAIT_IDLE.
REQ-029 If fbApplied is already 0 on entry, fbApply still clears on that cycle; no header is accepted while fbApply=1.
REQ-030 errUnknownChannel clears only on reset.
REQ-031 Input tvalid gaps mid-stream stall the counter; they cause no error.

Reset
REQ-032 On resetn low, asynchronously: state=WAIT_IDLE, all tvalid=0, s_cmd_axis_tready=0, m_cmd_axis_tlast=0, startRendering=0, fbApply=0, fbCmd=0, errUnknownChannel=0, counter=0, skid buffer empty.
REQ-033 Reset mid-stream abandons the stream; no partial tlast is emitted after release.

Structure
REQ-034 Opcode values, header field positions/sizes, and state encodings SHALL live in the shared package/include RegisterAndDescriptorDefines.
REQ-035 The skid buffer SHALL be one sub-module, axis_skid_buffer, parametrised by width.

Verification
REQ-036 W=32, header STREAM ch2 len 16 + 4 beats, ready high -> 4 beats on tvalid[2] in consecutive cycles, tlast on the 4th, no startRendering.
REQ-037 W=64, STREAM ch1 len 20 -> 3 beats, tlast on the 3rd, startRendering=1 until rasterizerRunning pulses.
REQ-038 Channel ready toggled 1/0 every cycle during an 8-beat stream -> all 8 beats delivered in order, none duplicated or lost.
REQ-039 STREAM ch7 with NUM_CHANNELS=5, len 8 -> 2 beats drained, no tvalid, errUnknownChannel=1, next header is accepted.
REQ-040 FRAMEBUFFER header 0x2000000F -> fbApply=1, fbCmd=0xF; fbApplied low 3 cycles then high -> fbApply clears; next header is accepted only after fbApplied=1.
REQ-041 resetn asserted mid-stream at beat 2 of 4 -> all outputs at reset values immediately (asynchronously); after release, a fresh header parses correctly.
